// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer (IDLE/DECODE/EXEC/MEM/WB/HALT) between fetch and datapath.
// Build macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes pulse err in EXEC and then halt.
module multicycle_control #(
    parameter int INSTR_W     = 16,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ack,
    output logic [1:0]         reg_dest,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               busy,
    output logic               halted,
    output logic               err
);
    localparam int CNT_W = 8;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {K_NOP, K_ALU, K_LD, K_ST, K_HALT, K_ILL} kind_t;

    state_t             state_reg, state_next;
    kind_t              kind_reg, kind_next, dec_kind;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ALUOP_W-1:0] alu_reg, alu_next, dec_alu;
    logic [1:0]         dest_reg, dest_next, dec_dest;
    logic               ready_reg, ready_next;
    logic               err_reg, err_next;
    logic               halted_reg, halted_next;
    logic [4:0]         opc;
    logic               unused_ir;

    assign opc       = ir_reg[INSTR_W-1 -: 5];
    assign unused_ir = ^ir_reg[INSTR_W-6:2];

    function automatic logic [ALUOP_W-1:0] funct_to_aluop(input logic [1:0] f);
        case (f)
            2'b00:   return '0;
            2'b01:   return ALUOP_W'(1);
            2'b10:   return ALUOP_W'(2);
            default: return ALUOP_W'(12);
        endcase
    endfunction

    // Decode of the held instruction; only latched at the end of DECODE.
    always_comb begin
        dec_kind = TRAP_EN ? K_ILL : K_NOP;
        dec_alu  = '0;
        dec_dest = 2'd3;
        if (opc == 5'b00000) begin
            dec_kind = K_HALT;
        end else if (opc == 5'b11001) begin
            dec_kind = K_ALU;
            dec_alu  = funct_to_aluop(ir_reg[1:0]);
            dec_dest = 2'd2;
        end else if (opc[4:3] == 2'b01) begin
            dec_kind = K_ALU;
            dec_alu  = funct_to_aluop(opc[1:0]);
            dec_dest = 2'd0;
        end else if (opc == 5'b10000) begin
            dec_kind = K_LD;
            dec_dest = 2'd0;
        end else if (opc == 5'b10001) begin
            dec_kind = K_ST;
            dec_dest = 2'd0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        kind_next   = kind_reg;
        ir_next     = ir_reg;
        cnt_next    = cnt_reg;
        alu_next    = alu_reg;
        dest_next   = dest_reg;
        err_next    = 1'b0;
        halted_next = halted_reg;
        case (state_reg)
            S_IDLE: begin
                if (instr_valid && ready_reg) begin
                    ir_next    = instr;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                kind_next  = dec_kind;
                alu_next   = dec_alu;
                dest_next  = dec_dest;
                state_next = S_EXEC;
                if (dec_kind == K_HALT) halted_next = 1'b1;
                if (dec_kind == K_ILL)  err_next    = 1'b1;
            end
            S_EXEC: begin
                case (kind_reg)
                    K_ALU:       state_next = S_WB;
                    K_LD, K_ST: begin
                        state_next = S_MEM;
                        cnt_next   = '0;
                    end
                    K_HALT:      state_next = S_HALT;
                    K_ILL: begin
                        state_next  = S_HALT;
                        halted_next = 1'b1;
                    end
                    default:     state_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // An ack in the final allowed cycle beats the timeout.
                if (mem_ack) begin
                    state_next = (kind_reg == K_LD) ? S_WB : S_IDLE;
                end else if (cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end
            end
            S_WB:    state_next = S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        if (state_next == S_IDLE) begin
            kind_next = K_NOP;
            alu_next  = '0;
            dest_next = 2'd0;
            cnt_next  = '0;
        end
    end

    // Registered ready keeps instr_ready low until the first edge after reset release.
    assign ready_next = (state_next == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            kind_reg   <= K_NOP;
            ir_reg     <= '0;
            cnt_reg    <= '0;
            alu_reg    <= '0;
            dest_reg   <= 2'd0;
            ready_reg  <= 1'b0;
            err_reg    <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            kind_reg   <= kind_next;
            ir_reg     <= ir_next;
            cnt_reg    <= cnt_next;
            alu_reg    <= alu_next;
            dest_reg   <= dest_next;
            ready_reg  <= ready_next;
            err_reg    <= err_next;
            halted_reg <= halted_next;
        end
    end

    assign instr_ready = ready_reg;
    assign busy        = (state_reg != S_IDLE);
    assign reg_write   = (state_reg == S_WB);
    assign mem_read    = (state_reg == S_MEM) && (kind_reg == K_LD);
    assign mem_write   = (state_reg == S_MEM) && (kind_reg == K_ST);
    assign mem_to_reg  = (state_reg == S_WB) && (kind_reg == K_LD);
    assign alu_op      = alu_reg;
    assign reg_dest    = dest_reg;
    assign halted      = halted_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instructions against a per-instruction outcome model.
module tb_multicycle_control;
    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        mem_ack = 1'b0;
    logic        instr_ready, reg_write, mem_read, mem_write, mem_to_reg, busy, halted, err;
    logic [1:0]  reg_dest;
    logic [3:0]  alu_op;

    multicycle_control #(.INSTR_W(16), .ALUOP_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .mem_ack(mem_ack), .reg_dest(reg_dest), .alu_op(alu_op),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected observable outcome of one instruction, offsets counted from the handshake cycle.
    typedef struct {
        int rw_cnt; int rw_off; int m2r; int rd; int wr; int err; int alu; int dest; int done;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam int NCAT = 4;
`else
    localparam int NCAT = 5;
`endif

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit known_opc(input logic [4:0] o);
        return (o == 5'b00000) || (o == 5'b11001) || (o[4:3] == 2'b01) ||
               (o == 5'b10000) || (o == 5'b10001);
    endfunction

    // d = cycle of MEM in which memory acks (1..15); 0 means never.
    function automatic exp_t model(input logic [15:0] ins, input int d);
        exp_t        e;
        logic [4:0]  opc;
        int          amap [4];
        int          f;
        int          mc;
        amap = '{0, 1, 2, 12};
        opc  = ins[15:11];
        e = '{rw_cnt: 0, rw_off: -1, m2r: 0, rd: 0, wr: 0, err: 0, alu: 0, dest: 3, done: 3};
        if (opc == 5'b11001 || opc[4:3] == 2'b01) begin
            f = (opc == 5'b11001) ? int'(ins[1:0]) : int'(opc[1:0]);
            e.alu    = amap[f];
            e.dest   = (opc == 5'b11001) ? 2 : 0;
            e.rw_cnt = 1;
            e.rw_off = 3;
            e.done   = 4;
        end else if (opc == 5'b10000 || opc == 5'b10001) begin
            e.dest = 0;
            mc = (d == 0) ? MEM_TIMEOUT : d;
            if (opc[0] == 1'b0) e.rd = mc; else e.wr = mc;
            if (d == 0) begin
                e.err  = 1;
                e.done = 3 + MEM_TIMEOUT;
            end else if (opc[0] == 1'b0) begin
                e.rw_cnt = 1;
                e.rw_off = 3 + d;
                e.m2r    = 1;
                e.done   = 4 + d;
            end else begin
                e.done = 3 + d;
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_instr(input int cat);
        logic [15:0] r;
        logic [4:0]  o;
        r = 16'($urandom);
        case (cat)
            0: r[15:11] = 5'b11001;
            1: r[15:14] = 2'b01;
            2: r[15:11] = 5'b10000;
            3: r[15:11] = 5'b10001;
            default: begin
                o = 5'b11111;
                for (int k = 0; k < 64; k++) begin
                    if (!known_opc(o)) break;
                    o = 5'($urandom);
                end
                r[15:11] = o;
            end
        endcase
        return r;
    endfunction

    // Memory responder: acks in the chosen MEM cycle, random noise on mem_ack otherwise.
    int cur_d = 0;
    int mem_cyc = 0;
    bit in_mem = 1'b0;
    initial forever begin
        @(negedge clk);
        if (mem_read || mem_write) begin
            if (!in_mem) begin
                in_mem  = 1'b1;
                mem_cyc = 1;
                cur_d   = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
            end else begin
                mem_cyc++;
            end
            mem_ack = (cur_d != 0) && (mem_cyc == cur_d);
        end else begin
            in_mem  = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: accumulates what the DUT shows per instruction and scores it on return to IDLE.
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    int   start_cyc, m_off, m_rw_cnt, m_rw_off, m_m2r, m_rd, m_wr, m_err, m_alu, m_dest;
    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("strobes_exclusive", (int'(reg_write) + int'(mem_read) + int'(mem_write) <= 1) ? 1 : 0, 1);
            if (active) begin
                m_off = cyc - start_cyc;
                if (m_off == 2) begin
                    m_alu  = int'(alu_op);
                    m_dest = int'(reg_dest);
                end
                if (reg_write) begin
                    m_rw_cnt++;
                    m_rw_off = m_off;
                    m_m2r    = int'(mem_to_reg);
                end
                m_rd  += int'(mem_read);
                m_wr  += int'(mem_write);
                m_err += int'(err);
                if (!busy) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL scoreboard: completion with empty queue, required a pending entry");
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("done_offset",   m_off,    mon_e.done);
                        chk("reg_write_cnt", m_rw_cnt, mon_e.rw_cnt);
                        chk("reg_write_off", m_rw_off, mon_e.rw_off);
                        chk("mem_to_reg_wb", m_m2r,    mon_e.m2r);
                        chk("mem_read_cyc",  m_rd,     mon_e.rd);
                        chk("mem_write_cyc", m_wr,     mon_e.wr);
                        chk("err_pulses",    m_err,    mon_e.err);
                        chk("alu_op_exec",   m_alu,    mon_e.alu);
                        chk("reg_dest_exec", m_dest,   mon_e.dest);
                        chk("ready_on_idle", int'(instr_ready), 1);
                        chk("m2r_idle",      int'(mem_to_reg), 0);
                    end
                    active = 1'b0;
                end else if (m_off > 60) begin
                    chk("instr_stuck_offset", m_off, 60);
                    active = 1'b0;
                end
            end
            if (instr_valid && instr_ready) begin
                active    = 1'b1;
                start_cyc = cyc;
                m_rw_cnt  = 0;  m_rw_off = -1; m_m2r = 0;
                m_rd      = 0;  m_wr     = 0;  m_err = 0;
                m_alu     = -1; m_dest   = -1;
            end
        end
    end

    task automatic accept(input logic [15:0] ins, output int c);
        int n;
        n = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            errors++;
            checks++;
            $display("FAIL accept_wait: instr_ready=0 after %0d cycles, required 1", n);
        end
        c = cyc;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_off(input int c, input int k);
        while (cyc - c < k) @(negedge clk);
        #1;
    endtask

    int last_acc = 0;
    int last_done = 0;
    task automatic issue(input logic [15:0] ins, input int d, input bit hold);
        exp_t e;
        int   n;
        e = model(ins, d);
        @(negedge clk);
        if (!hold) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        instr = ins;
        instr_valid = 1'b1;
        exp_q.push_back(e);
        if (ins[15:12] == 4'b1000) ack_q.push_back(d);
        n = 0;
        while (!instr_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            errors++;
            checks++;
            $display("FAIL issue_wait: instr_ready=0 after %0d cycles, required 1", n);
        end
        if (hold) chk("held_valid_accept_gap", cyc - last_acc, last_done);
        last_acc  = cyc;
        last_done = e.done;
        @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        // Reset values and the ready-after-release edge.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", int'({instr_ready, busy, halted, err, reg_write, mem_read,
                                   mem_write, mem_to_reg, reg_dest, alu_op}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", int'(instr_ready), 0);
        @(negedge clk);
        #1;
        chk("ready_after_edge", int'(instr_ready), 1);

        // Async reset in the middle of a load's MEM phase.
        ack_q.push_back(0);
        accept(16'h8000, c);
        wait_off(c, 4);
        chk("ld_mem_read_mid", int'(mem_read), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_read", int'(mem_read), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", int'(instr_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // Directed cases then random stream, all scored by the monitor.
        mon_en = 1'b1;
        issue(16'hC803, 0, 1'b0);
        issue(16'h4801, 0, 1'b0);
        issue(16'h4801, 0, 1'b1);
        issue(16'h8000, 3, 1'b0);
        issue(16'h8800, 0, 1'b0);
        issue(16'h8000, 0, 1'b1);
        issue(16'h8800, 15, 1'b0);
        issue(16'h8000, 1, 1'b1);
`ifndef CTRL_ILLEGAL_TRAP_EN
        issue(16'hF800, 0, 1'b0);
        issue(16'hC801, 0, 1'b1);
`endif
        for (int i = 0; i < 40; i++) begin
            issue(rand_instr($urandom_range(0, NCAT - 1)), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;

`ifdef CTRL_ILLEGAL_TRAP_EN
        // Illegal opcode traps: err in EXEC, then halted with ready stuck low.
        accept(16'hF800, c);
        wait_off(c, 2);
        chk("trap_err_exec", int'(err), 1);
        wait_off(c, 3);
        chk("trap_err_single", int'(err), 0);
        chk("trap_halted", int'(halted), 1);
        instr_valid = 1'b1;
        wait_off(c, 8);
        chk("trap_ready_stuck", int'(instr_ready), 0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // HALT: sticky halted, no further accepts until reset.
        accept(16'h0000, c);
        wait_off(c, 2);
        chk("halt_halted_exec", int'(halted), 1);
        chk("halt_no_err", int'(err), 0);
        instr_valid = 1'b1;
        wait_off(c, 10);
        chk("halt_ready_stuck", int'(instr_ready), 0);
        chk("halt_busy", int'(busy), 1);
        chk("halt_still_halted", int'(halted), 1);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_cleared_by_rst", int'(halted), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_halt_rst", int'(instr_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
